// File: rtl/cds_row_writer_if.sv
// Column sample write/readout bundle for cds_row_writer: ADC sample stream in,
// reset/signal banks plus row handshake out.
interface cds_row_writer_if #(
  parameter int unsigned mux_width       = 2,
  parameter int unsigned bus_width       = 8,
  parameter int unsigned row_count_width = 10
);
  logic                           sample_valid;
  logic [bus_width-1:0]           sample_data;
  logic                           sample_ready;
  logic                           frame_start;
  logic [mux_width*bus_width-1:0] reset_bank;
  logic [mux_width*bus_width-1:0] signal_bank;
  logic                           row_ready;
  logic                           row_ack;
  logic [row_count_width-1:0]     row_count;
  logic                           overrun;

  modport slave (
    input  sample_valid, sample_data, frame_start, row_ack,
    output sample_ready, reset_bank, signal_bank, row_ready, row_count, overrun
  );

  modport master (
    output sample_valid, sample_data, frame_start, row_ack,
    input  sample_ready, reset_bank, signal_bank, row_ready, row_count, overrun
  );
endinterface

// File: rtl/cds_row_writer.sv
// Fills the reset-level and signal-level column banks from a column-serial ADC
// stream and hands each completed row to the readout side via row_ready/row_ack.
module cds_row_writer #(
  parameter int unsigned mux_width       = 2,
  parameter int unsigned bus_width       = 8,
  parameter int unsigned row_count_width = 10
) (
  input logic             clk,
  input logic             reset,
  cds_row_writer_if.slave bus
);

  localparam int unsigned col_width = (mux_width > 1) ? $clog2(mux_width) : 1;
  localparam logic [col_width-1:0] last_col = col_width'(mux_width - 1);

  typedef enum logic [1:0] {WR_RST, WR_SIG, HOLD} state_t;

  state_t                         state;
  logic [col_width-1:0]           col;
  logic [mux_width*bus_width-1:0] reset_bank_q;
  logic [mux_width*bus_width-1:0] signal_bank_q;
  logic                           sample_ready_q;
  logic                           row_ready_q;
  logic [row_count_width-1:0]     row_count_q;
  logic                           overrun_q;
  logic                           accept;

  assign accept = bus.sample_valid && sample_ready_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= WR_RST;
      col            <= '0;
      reset_bank_q   <= '0;
      signal_bank_q  <= '0;
      sample_ready_q <= 1'b0;
      row_ready_q    <= 1'b0;
      row_count_q    <= '0;
      overrun_q      <= 1'b0;
    end else begin
      // Dropped samples are flagged even when frame_start wins the cycle.
      if (bus.sample_valid && !sample_ready_q)
        overrun_q <= 1'b1;

      if (bus.frame_start) begin
        state          <= WR_RST;
        col            <= '0;
        row_ready_q    <= 1'b0;
        sample_ready_q <= 1'b1;
        row_count_q    <= '0;
      end else begin
        case (state)
          WR_RST: begin
            sample_ready_q <= 1'b1;
            if (accept) begin
              reset_bank_q[col*bus_width +: bus_width] <= bus.sample_data;
              if (col == last_col) begin
                col   <= '0;
                state <= WR_SIG;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
          WR_SIG: begin
            if (accept) begin
              signal_bank_q[col*bus_width +: bus_width] <= bus.sample_data;
              if (col == last_col) begin
                col            <= '0;
                state          <= HOLD;
                sample_ready_q <= 1'b0;
                row_ready_q    <= 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
          HOLD: begin
            if (bus.row_ack) begin
              state          <= WR_RST;
              col            <= '0;
              row_ready_q    <= 1'b0;
              sample_ready_q <= 1'b1;
              row_count_q    <= row_count_q + 1'b1;
            end
          end
          default: begin
            state <= WR_RST;
            col   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.sample_ready = sample_ready_q;
  assign bus.reset_bank   = reset_bank_q;
  assign bus.signal_bank  = signal_bank_q;
  assign bus.row_ready    = row_ready_q;
  assign bus.row_count    = row_count_q;
  assign bus.overrun      = overrun_q;

endmodule
